// File: rtl/uart_text_writer.sv
// uart_text_writer
//   Terminal-style write controller between a UART receiver and an
//   NCOL x NROW character buffer. Printable ASCII is written at the cursor,
//   CR/LF/BS move the cursor, FF (and reset) start a full-screen sweep that
//   fills every cell with a space. One buffer write per cycle at most.
//
// Ports
//   clk      sole clock
//   rstn     synchronous active-low reset
//   rx_wr    one-cycle strobe, rx_data valid
//   rx_data  received byte
//   wr_en    buffer write strobe (one cycle per cell)
//   col_w    buffer write column
//   row_w    buffer write row
//   din      buffer write data (ASCII)
//   busy     high while a clear sweep is running
//   cur_col  cursor column
//   cur_row  cursor row

module uart_text_writer #(
    parameter int NCOL = 80,
    parameter int NROW = 30
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx_wr,
    input  logic [7:0] rx_data,
    output logic       wr_en,
    output logic [6:0] col_w,
    output logic [4:0] row_w,
    output logic [6:0] din,
    output logic       busy,
    output logic [6:0] cur_col,
    output logic [4:0] cur_row
);

    localparam logic [6:0] COL_MAX = 7'(NCOL - 1);
    localparam logic [4:0] ROW_MAX = 5'(NROW - 1);
    localparam logic [6:0] SPACE   = 7'h20;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t     state, state_d;

    logic [6:0] sw_col, sw_col_d;
    logic [4:0] sw_row, sw_row_d;
    logic       pend_v, pend_v_d;
    logic [7:0] pend, pend_d;

    logic       wr_en_d;
    logic [6:0] col_w_d;
    logic [4:0] row_w_d;
    logic [6:0] din_d;
    logic       busy_d;
    logic [6:0] cur_col_d;
    logic [4:0] cur_row_d;

    // Byte to process this cycle: a pending byte always goes first.
    logic       byte_v;
    logic [7:0] byte_in;
    logic       sweep_last;

    assign byte_v     = (state == IDLE) && (pend_v || rx_wr);
    assign byte_in    = pend_v ? pend : rx_data;
    assign sweep_last = (sw_col == COL_MAX) && (sw_row == ROW_MAX);

    // Row-major successor of a sweep position; wraps to (0,0) after the last
    // cell so the counter is already home when the sweep ends.
    function automatic logic [11:0] sweep_step(input logic [6:0] c,
                                                input logic [4:0] r);
        logic [6:0] nc;
        logic [4:0] nr;
        if (c == COL_MAX) begin
            nc = '0;
            nr = (r == ROW_MAX) ? '0 : r + 5'd1;
        end else begin
            nc = c + 7'd1;
            nr = r;
        end
        return {nr, nc};
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= CLEAR;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            CLEAR: if (sweep_last) state_d = IDLE;
            IDLE:  if (byte_v && (byte_in == 8'h0C)) state_d = CLEAR;
            default: state_d = CLEAR;
        endcase
    end

    // Output / datapath next values (all registered below)
    always_comb begin
        logic [11:0] step;

        sw_col_d  = sw_col;
        sw_row_d  = sw_row;
        pend_v_d  = pend_v;
        pend_d    = pend;
        wr_en_d   = 1'b0;
        col_w_d   = col_w;
        row_w_d   = row_w;
        din_d     = din;
        cur_col_d = cur_col;
        cur_row_d = cur_row;
        step      = '0;
        // Covers the cycle after an FF (entering CLEAR) and the cycle
        // carrying the final sweep write (leaving CLEAR).
        busy_d    = (state == CLEAR) || (state_d == CLEAR);

        if (state == CLEAR) begin
            if (rx_wr && !pend_v) begin
                pend_v_d = 1'b1;
                pend_d   = rx_data;
            end
            wr_en_d   = 1'b1;
            col_w_d   = sw_col;
            row_w_d   = sw_row;
            din_d     = SPACE;
            step      = sweep_step(sw_col, sw_row);
            sw_col_d  = step[6:0];
            sw_row_d  = step[11:7];
            cur_col_d = '0;
            cur_row_d = '0;
        end else begin
            // Pending byte is consumed now; a simultaneous new byte takes its slot.
            if (pend_v) begin
                if (rx_wr) begin
                    pend_d = rx_data;
                end else begin
                    pend_v_d = 1'b0;
                end
            end

            if (byte_v) begin
                case (byte_in)
                    8'h0D: cur_col_d = '0;
                    8'h0A: cur_row_d = (cur_row == ROW_MAX) ? '0 : cur_row + 5'd1;
                    8'h08: begin
                        if (cur_col != '0) begin
                            wr_en_d   = 1'b1;
                            col_w_d   = cur_col - 7'd1;
                            row_w_d   = cur_row;
                            din_d     = SPACE;
                            cur_col_d = cur_col - 7'd1;
                        end
                    end
                    8'h0C: begin
                        // First sweep cell is written in the FF cycle itself;
                        // CLEAR continues from the following cell.
                        wr_en_d   = 1'b1;
                        col_w_d   = '0;
                        row_w_d   = '0;
                        din_d     = SPACE;
                        step      = sweep_step('0, '0);
                        sw_col_d  = step[6:0];
                        sw_row_d  = step[11:7];
                        cur_col_d = '0;
                        cur_row_d = '0;
                    end
                    default: begin
                        if ((byte_in >= 8'h20) && (byte_in <= 8'h7E)) begin
                            wr_en_d = 1'b1;
                            col_w_d = cur_col;
                            row_w_d = cur_row;
                            din_d   = byte_in[6:0];
                            if (cur_col == COL_MAX) begin
                                cur_col_d = '0;
                                cur_row_d = (cur_row == ROW_MAX) ? '0 : cur_row + 5'd1;
                            end else begin
                                cur_col_d = cur_col + 7'd1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sw_col  <= '0;
            sw_row  <= '0;
            pend_v  <= 1'b0;
            pend    <= '0;
            wr_en   <= 1'b0;
            col_w   <= '0;
            row_w   <= '0;
            din     <= '0;
            busy    <= 1'b1;
            cur_col <= '0;
            cur_row <= '0;
        end else begin
            sw_col  <= sw_col_d;
            sw_row  <= sw_row_d;
            pend_v  <= pend_v_d;
            pend    <= pend_d;
            wr_en   <= wr_en_d;
            col_w   <= col_w_d;
            row_w   <= row_w_d;
            din     <= din_d;
            busy    <= busy_d;
            cur_col <= cur_col_d;
            cur_row <= cur_row_d;
        end
    end

endmodule

// File: tb/tb_uart_text_writer.sv
// tb_uart_text_writer
//   Self-checking bench for uart_text_writer: every expected buffer write is
//   queued when its stimulus is driven and compared when wr_en is seen.

module tb_uart_text_writer;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rx_wr = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       wr_en;
    logic [6:0] col_w;
    logic [4:0] row_w;
    logic [6:0] din;
    logic       busy;
    logic [6:0] cur_col;
    logic [4:0] cur_row;

    always #20 clk = ~clk;

    uart_text_writer #(.NCOL(80), .NROW(30)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .rx_wr   (rx_wr),
        .rx_data (rx_data),
        .wr_en   (wr_en),
        .col_w   (col_w),
        .row_w   (row_w),
        .din     (din),
        .busy    (busy),
        .cur_col (cur_col),
        .cur_row (cur_row)
    );

    typedef struct {
        int col;
        int row;
        int din;
    } wr_t;

    typedef struct {
        logic [7:0] data;
        bit         wr;
        int         col;
        int         row;
        int         din;
        int         ccol;
        int         crow;
    } vec_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  total = 0;
    int  bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Scoreboard consumer: every observed write must match the queue head.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: actual col=%0d row=%0d din=%0h required no write",
                         col_w, row_w, din);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_col", int'(col_w), mon_e.col);
                chk("wr_row", int'(row_w), mon_e.row);
                chk("wr_din", int'(din), mon_e.din);
            end
        end
    end

    task automatic push_sweep(input int ncells);
        for (int i = 0; i < ncells; i++) exp_q.push_back('{i % 80, i / 80, 32});
    endtask

    // One-cycle strobe; returns at the negedge where its result is visible.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_wr   = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_wr   = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        if (v.wr) exp_q.push_back('{v.col, v.row, v.din});
        send(v.data);
        chk({nm, "_wr_en"}, int'(wr_en), int'(v.wr));
        chk({nm, "_cur_col"}, int'(cur_col), v.ccol);
        chk({nm, "_cur_row"}, int'(cur_row), v.crow);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_wr_en"}, int'(wr_en), 0);
        chk({nm, "_col_w"}, int'(col_w), 0);
        chk({nm, "_row_w"}, int'(row_w), 0);
        chk({nm, "_din"}, int'(din), 0);
        chk({nm, "_busy"}, int'(busy), 1);
        chk({nm, "_cur_col"}, int'(cur_col), 0);
        chk({nm, "_cur_row"}, int'(cur_row), 0);
    endtask

    // Checks an uninterrupted sweep of n writes, busy high on the last one.
    task automatic sweep_cycles(input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({nm, "_wr_en"}, int'(wr_en), 1);
        end
        chk({nm, "_busy_last"}, int'(busy), 1);
    endtask

    vec_t t1[18];
    vec_t t2[4];
    vec_t v;

    initial begin
        t1 = '{
            '{8'h41, 1'b1, 0, 0, 'h41, 1, 0},
            '{8'h42, 1'b1, 1, 0, 'h42, 2, 0},
            '{8'h0D, 1'b0, 0, 0, 0,    0, 0},
            '{8'h0A, 1'b0, 0, 0, 0,    0, 1},
            '{8'h0A, 1'b0, 0, 0, 0,    0, 2},
            '{8'h0A, 1'b0, 0, 0, 0,    0, 3},
            '{8'h61, 1'b1, 0, 3, 'h61, 1, 3},
            '{8'h62, 1'b1, 1, 3, 'h62, 2, 3},
            '{8'h63, 1'b1, 2, 3, 'h63, 3, 3},
            '{8'h64, 1'b1, 3, 3, 'h64, 4, 3},
            '{8'h65, 1'b1, 4, 3, 'h65, 5, 3},
            '{8'h08, 1'b1, 4, 3, 'h20, 4, 3},
            '{8'h07, 1'b0, 0, 0, 0,    4, 3},
            '{8'hC1, 1'b0, 0, 0, 0,    4, 3},
            '{8'h7E, 1'b1, 4, 3, 'h7E, 5, 3},
            '{8'h1F, 1'b0, 0, 0, 0,    5, 3},
            '{8'h7F, 1'b0, 0, 0, 0,    5, 3},
            '{8'h20, 1'b1, 5, 3, 'h20, 6, 3}
        };
        t2 = '{
            '{8'h5A, 1'b1, 79, 29, 'h5A, 0, 0},
            '{8'h0D, 1'b0, 0,  0,  0,    0, 0},
            '{8'h0A, 1'b0, 0,  0,  0,    0, 1},
            '{8'h08, 1'b0, 0,  0,  0,    0, 1}
        };

        // Reset state and power-on sweep
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        push_sweep(2400);
        rstn = 1'b1;
        sweep_cycles(2400, "init_sweep");
        @(negedge clk);
        chk("init_busy_fall", int'(busy), 0);
        chk("init_idle_wr_en", int'(wr_en), 0);
        chk("init_cur_col", int'(cur_col), 0);
        chk("init_cur_row", int'(cur_row), 0);
        chk("init_queue_empty", exp_q.size(), 0);

        // Printable, CR, LF, BS, ignored codes
        for (int i = 0; i < 18; i++) run_vec(t1[i], $sformatf("t1_%0d", i));

        // Walk cursor to (79,29)
        send(8'h0D);
        for (int i = 0; i < 26; i++) send(8'h0A);
        chk("walk_row29", int'(cur_row), 29);
        for (int i = 0; i < 79; i++) begin
            v = '{8'h78, 1'b1, i, 29, 'h78, i + 1, 29};
            run_vec(v, "fill_row29");
        end

        // Full wrap from last cell, then CR / LF / BS at column 0
        for (int i = 0; i < 4; i++) run_vec(t2[i], $sformatf("t2_%0d", i));

        // LF wrap from the last row
        for (int i = 0; i < 28; i++) send(8'h0A);
        v = '{8'h0A, 1'b0, 0, 0, 0, 0, 0};
        run_vec(v, "lf_wrap");

        // Move to (10,10)
        for (int i = 0; i < 10; i++) send(8'h0A);
        for (int i = 0; i < 10; i++) begin
            v = '{8'h79, 1'b1, i, 10, 'h79, i + 1, 10};
            run_vec(v, "to_10_10");
        end

        // Form feed: sweep, one byte pended, two dropped
        push_sweep(2400);
        exp_q.push_back('{0, 0, 'h51});
        send(8'h0C);
        chk("ff_busy", int'(busy), 1);
        chk("ff_first_wr_en", int'(wr_en), 1);
        chk("ff_cur_col", int'(cur_col), 0);
        chk("ff_cur_row", int'(cur_row), 0);
        for (int i = 1; i < 2400; i++) begin
            @(negedge clk);
            chk("ff_sweep_wr_en", int'(wr_en), 1);
            rx_wr = 1'b0;
            if (i == 100) begin rx_wr = 1'b1; rx_data = 8'h51; end
            if (i == 500) begin rx_wr = 1'b1; rx_data = 8'h52; end
            if (i == 900) begin rx_wr = 1'b1; rx_data = 8'h53; end
        end
        chk("ff_busy_last", int'(busy), 1);
        @(negedge clk);
        chk("ff_busy_fall", int'(busy), 0);
        chk("ff_pend_wr_en", int'(wr_en), 1);
        chk("ff_pend_cur_col", int'(cur_col), 1);
        chk("ff_pend_cur_row", int'(cur_row), 0);
        @(negedge clk);
        chk("ff_dropped_wr_en", int'(wr_en), 0);
        repeat (4) @(negedge clk);
        chk("ff_queue_empty", exp_q.size(), 0);

        // Reset mid-sweep at cell 1000, with a byte pending that must be lost
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset2");
        push_sweep(1000);
        rstn = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            chk("mid_sweep_wr_en", int'(wr_en), 1);
            rx_wr = 1'b0;
            if (i == 500) begin rx_wr = 1'b1; rx_data = 8'h50; end
        end
        rx_wr = 1'b0;
        rstn  = 1'b0;
        @(negedge clk);
        chk_reset_outputs("reset_mid");
        chk("reset_mid_queue", exp_q.size(), 0);
        push_sweep(2400);
        rstn = 1'b1;
        sweep_cycles(2400, "restart_sweep");
        @(negedge clk);
        chk("restart_busy_fall", int'(busy), 0);
        chk("restart_no_pend_wr", int'(wr_en), 0);
        chk("restart_cur_col", int'(cur_col), 0);
        chk("restart_cur_row", int'(cur_row), 0);
        repeat (4) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
